la_capture_core: RTL and testbench
==================================

# la_capture_core

Parametrised on-chip logic-analyser capture core, the successor to the fixed 4-channel analyser instance in the DDR test design. It samples `WIDTH` probe channels every `clk_i` cycle into a `DEPTH`-entry circular buffer. Trigger conditions are programmable per channel, as level or edge, combined with AND or OR. The pre-/post-trigger split is programmable, and the buffer is read back through a simple synchronous port. It sits in the probed clock domain (e.g. `memory_clk`); control/readout bridging to JTAG lives outside this block.

## Interface
- `WIDTH`, 8: number of probe channels (1..64).
- `DEPTH`, 1024: buffer entries; power of two, ≥4.
- `AW`, $clog2(DEPTH): address width (derived, not overridden).

- `clk_i` in 1: sample clock; all logic on rising edge.
- `rst_n_i` in 1: asynchronous, active-low reset.
- `data_i` in WIDTH: probe inputs.
- `arm_i` in 1: start capture (single-cycle pulse).
- `abort_i` in 1: cancel capture.
- `trig_mask_i` in WIDTH: 1 = channel participates in trigger.
- `trig_value_i` in WIDTH: level or post-edge value per channel.
- `trig_edge_i` in WIDTH: 0 = level match, 1 = edge into `trig_value_i`.
- `trig_or_i` in 1: 0 = AND of enabled terms, 1 = OR.
- `pretrig_i` in AW: samples kept before the trigger sample.
- `state_o` out 3: IDLE=0, PRE=1, WAIT=2, POST=3, DONE=4.
- `done_o` out 1: high while in DONE.
- `start_addr_o` out AW: buffer address of the oldest sample of the capture.
- `trig_addr_o` out AW: buffer address of the trigger sample.
- `rd_en_i` in 1: read request.
- `rd_addr_i` in AW: read address.
- `rd_data_o` out WIDTH: read data.
- `rd_valid_o` out 1: `rd_data_o` valid.

## Operation
- Input stage: `s1 <= data_i`; `s2 <= s1`. The buffer is written with `s1`. The trigger is evaluated on `s1`, with `s2` as the previous sample.
- Per-channel term when `mask[i]=1`:
  - level: `s1[i]==value[i]`;
  - edge: `s1[i]==value[i] && s2[i]!=value[i]`.
  - Masked-off terms are excluded.
- Combination: AND or OR of the enabled terms. If all mask bits are 0, the trigger is true on the first eligible cycle in either mode.
- Arm:
  - `arm_i` is accepted in IDLE or DONE only.
  - On acceptance: latch `pretrig_i`, `trig_*` and `trig_or_i`; set `wr_ptr<=0`; clear `done_o`.
  - If the latched pretrig is 0 the FSM goes to WAIT, otherwise to PRE.
  - `arm_i` is ignored in PRE/WAIT/POST.
- PRE: write `s1` at `wr_ptr` and increment. After exactly `pretrig` writes, go to WAIT. Trigger is ignored in PRE.
- WAIT: write every cycle; `wr_ptr` wraps modulo DEPTH. On the first cycle the trigger is true:
  - the sample is written;
  - `trig_addr_o<=wr_ptr`;
  - `start_addr_o<=wr_ptr-pretrig` (mod DEPTH);
  - `post_cnt<=DEPTH-1-pretrig`;
  - go to POST, or straight to DONE if `post_cnt` would be 0.
- POST: write and decrement `post_cnt`. The last write takes the FSM to DONE. The buffer then holds exactly DEPTH samples, oldest at `start_addr_o`, trigger at offset `pretrig`.
- DONE: no writes; buffer and addresses frozen until the next arm.
- Abort:
  - `abort_i` in any state sends the FSM to IDLE next cycle, with `done_o=0`.
  - Abort has priority over `arm_i` and over a trigger in the same cycle.
  - Buffer contents are undefined after an abort.
- Readout: `rd_en_i` is honoured only in IDLE or DONE. Otherwise it is ignored and `rd_valid_o` stays 0.

## Timing
- Reset values: `state_o=0`, `done_o=0`, `start_addr_o=0`, `trig_addr_o=0`, `rd_data_o=0`, `rd_valid_o=0`, `wr_ptr=0`, `s1=s2=0`.
- Write latency: `data_i` at edge t is written at edge t+1.
- Trigger latency: a `data_i` change at edge t makes the trigger true in the cycle after t+1. The FSM is in POST one cycle later.
- Read latency: 1 cycle. `rd_data_o` and `rd_valid_o` are registered, and `rd_valid_o` is a one-cycle pulse per accepted `rd_en_i`. Back-to-back reads give one result per cycle.
- Arm to WAIT: pretrig+1 cycles. Trigger sample to `done_o`: DEPTH-1-pretrig cycles.
- The buffer infers a simple dual-port RAM: one write port, one registered read port.
- Reset mid-capture: immediate return to IDLE; no partial `done_o`.

## Test plan
- **Level trigger.** WIDTH=4, DEPTH=16, pretrig=4, mask=0001, edge=0, value=1. Drive a counter on `data_i` and arm. Required: `done_o` rises after 16 total writes; `start_addr_o=trig_addr_o-4` mod 16; the 16 read samples are consecutive counter values with the trigger at offset 4.
- **Edge vs level.** Hold ch0=1 before arming with edge=1, value=1. Required: no trigger until ch0 goes 0→1; a level trigger with the same setup fires on the first WAIT cycle.
- **AND/OR.** mask=0011, value=0011, with ch0 and ch1 high at different times. Required: OR fires on the first high; AND fires only when both are high.
- **Boundaries.**
  - pretrig=0: the trigger sample is at `start_addr_o`.
  - pretrig=15: DONE one cycle after the trigger.
  - mask=0: triggers immediately.
  - A trigger that arrives after `wr_ptr` has wrapped at least twice gives the correct `start_addr_o`.
- **Abort and re-arm.** Abort in WAIT together with a trigger. Required: IDLE, `done_o=0`. Assert `arm_i` during POST: it is ignored. Re-arm in DONE: a clean second capture.
- **Read gating and reset.** Assert `rd_en_i` in WAIT: `rd_valid_o` stays 0. Assert `rst_n_i` low in POST: all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/la_capture_core.sv
// la_capture_core: logic-analyser capture core with programmable trigger, pre/post split and circular buffer
module la_capture_core #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 1024,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             arm_i,
    input  logic             abort_i,
    input  logic [WIDTH-1:0] trig_mask_i,
    input  logic [WIDTH-1:0] trig_value_i,
    input  logic [WIDTH-1:0] trig_edge_i,
    input  logic             trig_or_i,
    input  logic [AW-1:0]    pretrig_i,
    output logic [2:0]       state_o,
    output logic             done_o,
    output logic [AW-1:0]    start_addr_o,
    output logic [AW-1:0]    trig_addr_o,
    input  logic             rd_en_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             rd_valid_o
);
    typedef enum logic [2:0] {S_IDLE = 3'd0, S_PRE = 3'd1, S_WAIT = 3'd2, S_POST = 3'd3, S_DONE = 3'd4} state_t;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] s1_q, s2_q;
    logic [WIDTH-1:0] mask_q, mask_d, val_q, val_d, edge_q, edge_d;
    logic             or_q, or_d;
    logic [AW-1:0]    pre_q, pre_d, wr_ptr_q, wr_ptr_d, post_q, post_d;
    logic [AW-1:0]    start_q, start_d, trig_q, trig_d;
    logic [WIDTH-1:0] rd_data_q;
    logic             rd_valid_q;
    logic [WIDTH-1:0] term;
    logic             hit, wr_en, rd_ok;
    logic [WIDTH-1:0] mem [DEPTH];
    always_comb begin
        // edge terms additionally require the previous sample to differ from the target value
        term   = ~(s1_q ^ val_q) & (~edge_q | (s2_q ^ val_q));
        hit    = ~|mask_q ? 1'b1 : or_q ? |(term & mask_q) : &(term | ~mask_q);
        wr_en  = state_q == S_PRE || state_q == S_WAIT || state_q == S_POST;
        rd_ok  = rd_en_i && (state_q == S_IDLE || state_q == S_DONE);
        state_d  = state_q;
        mask_d   = mask_q;
        val_d    = val_q;
        edge_d   = edge_q;
        or_d     = or_q;
        pre_d    = pre_q;
        wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
        post_d   = post_q;
        start_d  = start_q;
        trig_d   = trig_q;
        case (state_q)
            S_IDLE, S_DONE: if (arm_i) begin
                mask_d   = trig_mask_i;
                val_d    = trig_value_i;
                edge_d   = trig_edge_i;
                or_d     = trig_or_i;
                pre_d    = pretrig_i;
                wr_ptr_d = '0;
                state_d  = pretrig_i == '0 ? S_WAIT : S_PRE;
            end
            S_PRE: state_d = wr_ptr_q == pre_q - AW'(1) ? S_WAIT : S_PRE;
            S_WAIT: if (hit) begin
                trig_d  = wr_ptr_q;
                start_d = wr_ptr_q - pre_q;
                post_d  = AW'(DEPTH - 1) - pre_q;
                state_d = pre_q == AW'(DEPTH - 1) ? S_DONE : S_POST;
            end
            S_POST: begin
                post_d  = post_q - AW'(1);
                state_d = post_q == AW'(1) ? S_DONE : S_POST;
            end
            default: state_d = S_IDLE;
        endcase
        if (abort_i) state_d = S_IDLE;
    end
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= S_IDLE;
            s1_q       <= '0;
            s2_q       <= '0;
            mask_q     <= '0;
            val_q      <= '0;
            edge_q     <= '0;
            or_q       <= 1'b0;
            pre_q      <= '0;
            wr_ptr_q   <= '0;
            post_q     <= '0;
            start_q    <= '0;
            trig_q     <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            s1_q       <= data_i;
            s2_q       <= s1_q;
            mask_q     <= mask_d;
            val_q      <= val_d;
            edge_q     <= edge_d;
            or_q       <= or_d;
            pre_q      <= pre_d;
            wr_ptr_q   <= wr_ptr_d;
            post_q     <= post_d;
            start_q    <= start_d;
            trig_q     <= trig_d;
            rd_valid_q <= rd_ok;
            if (rd_ok) rd_data_q <= mem[rd_addr_i];
        end
    end
    always_ff @(posedge clk_i) begin
        if (wr_en) mem[wr_ptr_q] <= s1_q;
    end
    assign state_o      = state_q;
    assign done_o       = state_q == S_DONE;
    assign start_addr_o = start_q;
    assign trig_addr_o  = trig_q;
    assign rd_data_o    = rd_data_q;
    assign rd_valid_o   = rd_valid_q;
endmodule

// File: tb/tb_la_capture_core.sv
// tb_la_capture_core: directed scoreboard bench for la_capture_core (WIDTH=4, DEPTH=16)
module tb_la_capture_core;
    localparam int W = 4, D = 16, AW = 4;
    logic          clk = 1'b0, rst_n = 1'b0;
    logic [W-1:0]  data = '0, mask = '0, val = '0, edg = '0;
    logic          arm = 1'b0, abort = 1'b0, orr = 1'b0, rd_en = 1'b0;
    logic [AW-1:0] pre = '0, rd_addr = '0;
    logic [2:0]    state;
    logic          done, rd_valid;
    logic [AW-1:0] start_addr, trig_addr;
    logic [W-1:0]  rd_data;
    int            checks = 0, fails = 0, n;
    bit            count_en = 0;
    logic [W-1:0]  exp_q [$];

    la_capture_core #(.WIDTH(W), .DEPTH(D)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .data_i(data), .arm_i(arm), .abort_i(abort),
        .trig_mask_i(mask), .trig_value_i(val), .trig_edge_i(edg), .trig_or_i(orr),
        .pretrig_i(pre), .state_o(state), .done_o(done), .start_addr_o(start_addr),
        .trig_addr_o(trig_addr), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
        .rd_data_o(rd_data), .rd_valid_o(rd_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (count_en) data = data + 1'b1;
    endtask

    task automatic arm_cap(input logic [AW-1:0] p, input logic [W-1:0] m, input logic [W-1:0] v,
                           input logic [W-1:0] e, input logic o);
        pre = p; mask = m; val = v; edg = e; orr = o;
        arm = 1'b1;
        step();
        arm = 1'b0;
    endtask

    task automatic run_to_done(output int cnt);
        cnt = 0;
        while (!done && cnt < 64) begin
            step();
            cnt++;
        end
        chk("done_reached", done, 1);
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [W-1:0] e);
        exp_q.push_back(e);
        rd_en = 1'b1; rd_addr = a;
        step();
        rd_en = 1'b0;
    endtask

    task automatic drain();
        step(); step();
        chk("read_drain", exp_q.size(), 0);
    endtask

    task automatic do_abort();
        abort = 1'b1;
        step();
        abort = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rd_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL rd_unexpected: got valid data %0d expected no read", rd_data);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                if (rd_data !== e) begin
                    fails++;
                    $display("FAIL rd_data: got %0d expected %0d", rd_data, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        #12;
        chk("rst_state", state, 0);
        chk("rst_done", done, 0);
        chk("rst_start", start_addr, 0);
        chk("rst_trig", trig_addr, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_rd_valid", rd_valid, 0);
        rst_n = 1'b1;
        step();

        // level trigger on ch0 with counter data: D0=1, trigger on first WAIT cycle
        data = 4'd1; count_en = 1;
        arm_cap(4'd4, 4'b0001, 4'b0001, 4'b0000, 1'b0);
        chk("t1_pre", state, 1);
        run_to_done(n);
        chk("t1_writes", n, 16);
        chk("t1_trig", trig_addr, 4);
        chk("t1_start", start_addr, 0);
        count_en = 0;
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(W'(i + 1));
            rd_en = 1'b1; rd_addr = AW'(i);
            step();
        end
        rd_en = 1'b0;
        drain();

        // edge trigger: ch0 held high must not fire until a 0->1 transition
        data = 4'd1; step(); step();
        arm_cap(4'd0, 4'b0001, 4'b0001, 4'b0001, 1'b0);
        repeat (5) step();
        chk("t2_no_edge", state, 2);
        data = 4'd0; step();
        data = 4'd1; step();
        chk("t2_still_wait", state, 2);
        step();
        chk("t2_post", state, 3);
        chk("t2_trig", trig_addr, 7);
        chk("t2_start_eq_trig", start_addr, 7);
        run_to_done(n);
        chk("t2_post_len", n, 15);
        rd(4'd7, 4'd1);
        drain();

        // level with same setup fires on first WAIT cycle; re-arm from DONE; arm in POST ignored
        arm_cap(4'd0, 4'b0001, 4'b0001, 4'b0000, 1'b0);
        chk("t3_wait", state, 2);
        chk("t3_done_clr", done, 0);
        step();
        chk("t3_post", state, 3);
        chk("t3_trig", trig_addr, 0);
        arm_cap(4'd3, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        chk("t3_arm_ignored", state, 3);
        run_to_done(n);
        chk("t3_post_len", n, 14);

        // OR: fires on ch0 alone
        data = 4'd0; step(); step();
        arm_cap(4'd0, 4'b0011, 4'b0011, 4'b0000, 1'b1);
        step(); step();
        chk("t4_or_wait", state, 2);
        data = 4'd1; step();
        chk("t4_or_wait2", state, 2);
        step();
        chk("t4_or_post", state, 3);
        chk("t4_or_trig", trig_addr, 3);
        do_abort();
        chk("t4_abort_state", state, 0);
        chk("t4_abort_done", done, 0);

        // AND: needs ch0 and ch1 together
        data = 4'd0; step();
        arm_cap(4'd0, 4'b0011, 4'b0011, 4'b0000, 1'b0);
        data = 4'd1; step(); step();
        chk("t5_and_ch0", state, 2);
        data = 4'd2; step(); step();
        chk("t5_and_ch1", state, 2);
        data = 4'd3; step();
        chk("t5_and_wait", state, 2);
        step();
        chk("t5_and_post", state, 3);
        chk("t5_and_trig", trig_addr, 5);
        do_abort();

        // abort wins over a simultaneous trigger and arm
        data = 4'd0; step();
        arm_cap(4'd0, 4'b0011, 4'b0011, 4'b0000, 1'b0);
        data = 4'd3; step();
        abort = 1'b1; arm = 1'b1;
        step();
        abort = 1'b0; arm = 1'b0;
        chk("t6_abort_state", state, 0);
        chk("t6_abort_done", done, 0);

        // reads are ignored outside IDLE/DONE
        data = 4'd0; step();
        arm_cap(4'd0, 4'b0011, 4'b0011, 4'b0000, 1'b0);
        rd_en = 1'b1; rd_addr = 4'd2;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t7_rd_gated", rd_valid, 0);
        end
        rd_en = 1'b0;
        do_abort();

        // pretrig=15 with mask=0: immediate trigger, DONE right after it
        data = 4'd0; count_en = 1;
        arm_cap(4'd15, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        repeat (15) step();
        chk("t8_wait", state, 2);
        step();
        chk("t8_done_state", state, 4);
        chk("t8_done", done, 1);
        chk("t8_trig", trig_addr, 15);
        chk("t8_start", start_addr, 0);
        count_en = 0;
        rd(4'd0, 4'd0);
        rd(4'd4, 4'd4);
        rd(4'd15, 4'd15);
        drain();

        // trigger after wr_ptr has wrapped twice
        data = 4'd0; step(); step();
        arm_cap(4'd2, 4'b0001, 4'b0001, 4'b0000, 1'b0);
        step(); step();
        chk("t9_wait", state, 2);
        repeat (35) step();
        chk("t9_no_trig", state, 2);
        data = 4'd1; step(); step();
        chk("t9_post", state, 3);
        chk("t9_trig", trig_addr, 6);
        chk("t9_start", start_addr, 4);

        // asynchronous reset in POST
        #2 rst_n = 1'b0;
        #1;
        chk("t10_state", state, 0);
        chk("t10_done", done, 0);
        chk("t10_start", start_addr, 0);
        chk("t10_trig", trig_addr, 0);
        chk("t10_rd_data", rd_data, 0);
        chk("t10_rd_valid", rd_valid, 0);
        step();
        rst_n = 1'b1;
        step();
        chk("t10_idle_after", state, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
